vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- HDISP, 800, active pixels per line.
- VDISP, 480, active lines per frame.
- HFP, 40, horizontal front porch in cycles.
- HPULSE, 48, horizontal sync pulse in cycles.
- HBP, 40, horizontal back porch in cycles.
- VFP, 13, vertical front porch in lines.
- VPULSE, 3, vertical sync pulse in lines.
- VBP, 29, vertical back porch in lines.
- PIPE_LAT, 2, latency in cycles between a pixel request and its sync/blank alignment; range 1..8.
- HS_POL, 0, active level of VGA_HS.
- VS_POL, 0, active level of VGA_VS.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1, pixel clock.
- NRST, in, 1, asynchronous active-low reset.
- en, in, 1, run enable.
- req_valid, out, 1, pixel request for the current coordinates.
- req_x, out, clog2(HDISP), request column.
- req_y, out, clog2(VDISP), request row.
- line_start, out, 1, one-cycle pulse at hcount==0.
- frame_start, out, 1, one-cycle pulse at hcount==0 and vcount==0.
- VGA_HS, out, 1, horizontal sync.
- VGA_VS, out, 1, vertical sync.
- VGA_BLANK, out, 1, high during active video.
- VGA_SYNC, out, 1, tied to 0.

REQ-003 The block SHALL use one clock, CLK; reset SHALL be NRST, asynchronous and active-low.

Function
REQ-004 HTOTAL SHALL be HDISP+HFP+HPULSE+HBP, VTOTAL SHALL be VDISP+VFP+VPULSE+VBP, HBLANK SHALL be HFP+HPULSE+HBP, and VBLANK SHALL be VFP+VPULSE+VBP.
REQ-005 hcount (width clog2(HTOTAL)) SHALL increment every cycle while en=1 and wrap from HTOTAL-1 to 0.
REQ-006 vcount SHALL increment when hcount wraps and SHALL itself wrap from VTOTAL-1 to 0 in the same cycle.
REQ-007 Horizontal regions SHALL be: front porch for hcount < HFP; sync for HFP ≤ hcount < HFP+HPULSE; back porch for HFP+HPULSE ≤ hcount < HBLANK; active for hcount ≥ HBLANK.
REQ-008 Vertical regions SHALL be identical to the horizontal regions, using vcount and the V parameters.
REQ-009 req_valid SHALL be registered and SHALL be 1 exactly when both hcount and vcount are in their active regions.
REQ-010 While req_valid=1, req_x SHALL equal hcount-HBLANK and req_y SHALL equal vcount-VBLANK; while req_valid=0, both SHALL be 0.
REQ-011 Raw hsync, vsync and blank SHALL be derived in the same cycle as req_valid and then delayed by a PIPE_LAT-stage shift register to drive VGA_HS, VGA_VS and VGA_BLANK.
REQ-012 As a consequence of REQ-011, the VGA_BLANK high for a pixel SHALL occur exactly PIPE_LAT cycles after its req_valid.
REQ-013 VGA_HS SHALL equal HS_POL during horizontal sync and ~HS_POL otherwise; VGA_VS SHALL follow the same rule with VS_POL.
REQ-014 line_start and frame_start SHALL be registered, aligned with req_valid, and not delayed by PIPE_LAT.
REQ-015 en=0 SHALL freeze hcount and vcount and force req_valid, line_start and frame_start to 0; the delay line SHALL keep shifting, with inactive values injected at its input.
REQ-016 en 0->1 SHALL resume counting from the frozen counts, with no restart.
REQ-017 Parameter legality SHALL be checked at elaboration: PIPE_LAT outside 1..8, or any of HDISP, VDISP, HPULSE, VPULSE equal to 0, SHALL cause a fatal error.

Reset
REQ-018 NRST=0 SHALL immediately set hcount=0, vcount=0, req_valid=0, req_x=0, req_y=0, line_start=0, frame_start=0, all delay stages inactive, VGA_HS=~HS_POL, VGA_VS=~VS_POL, VGA_BLANK=0 and VGA_SYNC=0.
REQ-019 After NRST is released with en=1, the first clock edge SHALL produce frame_start=1 and line_start=1.
REQ-020 Reset asserted mid-frame SHALL abort the frame with no residual pulses after release.

Verification
Bench parameters: HDISP=160, VDISP=90, HFP=4, HPULSE=8, HBP=4, VFP=1, VPULSE=2, VBP=2, PIPE_LAT=3, giving HTOTAL=176, VTOTAL=95 and 16720 cycles per frame.
REQ-021 Release NRST with en=1 -> frame_start pulses every 16720 cycles and line_start every 176 cycles.
REQ-022 Count over one frame -> 14400 cycles with req_valid=1 and 14400 with VGA_BLANK=1; VGA_HS low for 8 cycles per line; VGA_VS low for 2×176=352 cycles per frame.
REQ-023 First active pixel -> req_valid rises with req_x=0, req_y=0; VGA_BLANK rises exactly 3 cycles later; the last request of the frame has req_x=159, req_y=89.
REQ-024 Drop en for 50 cycles mid-line -> counts freeze; VGA_BLANK falls within 3 cycles; on resume req_x continues from the frozen value.
REQ-025 Assert NRST mid-frame -> outputs take the REQ-018 values immediately; after release the next frame_start occurs on the first edge.
REQ-026 Rerun with HS_POL=1, VS_POL=1 -> VGA_HS and VGA_VS are inverted, with identical timing.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running h/v counters produce pixel requests,
// with sync/blank delayed through a PIPE_LAT-stage line to meet the pixel pipeline.
module vga_timing_gen #(
  parameter int HDISP    = 800,
  parameter int VDISP    = 480,
  parameter int HFP      = 40,
  parameter int HPULSE   = 48,
  parameter int HBP      = 40,
  parameter int VFP      = 13,
  parameter int VPULSE   = 3,
  parameter int VBP      = 29,
  parameter int PIPE_LAT = 2,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  localparam int XW      = (HDISP > 1) ? $clog2(HDISP) : 1,
  localparam int YW      = (VDISP > 1) ? $clog2(VDISP) : 1
) (
  input  logic          CLK,
  input  logic          NRST,
  input  logic          en,
  output logic          req_valid,
  output logic [XW-1:0] req_x,
  output logic [YW-1:0] req_y,
  output logic          line_start,
  output logic          frame_start,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK,
  output logic          VGA_SYNC
);

  localparam int HBLANK = HFP + HPULSE + HBP;
  localparam int VBLANK = VFP + VPULSE + VBP;
  localparam int HTOTAL = HDISP + HBLANK;
  localparam int VTOTAL = VDISP + VBLANK;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);

  localparam logic [HW-1:0] HLAST_C    = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] VLAST_C    = VW'(VTOTAL - 1);
  localparam logic [HW-1:0] HSYNC_LO_C = HW'(HFP);
  localparam logic [HW-1:0] HSYNC_HI_C = HW'(HFP + HPULSE);
  localparam logic [VW-1:0] VSYNC_LO_C = VW'(VFP);
  localparam logic [VW-1:0] VSYNC_HI_C = VW'(VFP + VPULSE);
  localparam logic [HW-1:0] HBLANK_C   = HW'(HBLANK);
  localparam logic [VW-1:0] VBLANK_C   = VW'(VBLANK);

  if (PIPE_LAT < 1 || PIPE_LAT > 8 || HDISP == 0 || VDISP == 0 ||
      HPULSE == 0 || VPULSE == 0) begin : gBadParams
    $fatal(1, "vga_timing_gen: illegal parameter set");
  end

  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;

  logic          reqValid_q;
  logic [XW-1:0] reqX_q;
  logic [YW-1:0] reqY_q;
  logic          lineStart_q;
  logic          frameStart_q;

  logic          hsRaw_q, vsRaw_q, blankRaw_q;
  logic [PIPE_LAT-1:0] hsPipe_q, vsPipe_q, blankPipe_q;

  logic hActive, vActive, hSync, vSync, activeNow;
  logic [XW-1:0] reqXNow;
  logic [YW-1:0] reqYNow;

  always_comb begin
    hActive   = (hcount_q >= HBLANK_C);
    vActive   = (vcount_q >= VBLANK_C);
    hSync     = (hcount_q >= HSYNC_LO_C) && (hcount_q < HSYNC_HI_C);
    vSync     = (vcount_q >= VSYNC_LO_C) && (vcount_q < VSYNC_HI_C);
    activeNow = en && hActive && vActive;
    reqXNow   = XW'(hcount_q - HBLANK_C);
    reqYNow   = YW'(vcount_q - VBLANK_C);
  end

  // Counters hold their value while en is low so a resume continues the same line.
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (en) begin
      if (hcount_q == HLAST_C) begin
        hcount_d = '0;
        vcount_d = (vcount_q == VLAST_C) ? '0 : vcount_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      hcount_q     <= '0;
      vcount_q     <= '0;
      reqValid_q   <= 1'b0;
      reqX_q       <= '0;
      reqY_q       <= '0;
      lineStart_q  <= 1'b0;
      frameStart_q <= 1'b0;
      hsRaw_q      <= 1'b0;
      vsRaw_q      <= 1'b0;
      blankRaw_q   <= 1'b0;
      hsPipe_q     <= '0;
      vsPipe_q     <= '0;
      blankPipe_q  <= '0;
    end else begin
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      reqValid_q   <= activeNow;
      reqX_q       <= activeNow ? reqXNow : '0;
      reqY_q       <= activeNow ? reqYNow : '0;
      lineStart_q  <= en && (hcount_q == '0);
      frameStart_q <= en && (hcount_q == '0) && (vcount_q == '0);
      // Raw flags line up with req_valid; the delay line then adds exactly PIPE_LAT cycles.
      hsRaw_q      <= en && hSync;
      vsRaw_q      <= en && vSync;
      blankRaw_q   <= activeNow;
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        hsPipe_q[i]    <= hsPipe_q[i-1];
        vsPipe_q[i]    <= vsPipe_q[i-1];
        blankPipe_q[i] <= blankPipe_q[i-1];
      end
      hsPipe_q[0]    <= hsRaw_q;
      vsPipe_q[0]    <= vsRaw_q;
      blankPipe_q[0] <= blankRaw_q;
    end
  end

  assign req_valid   = reqValid_q;
  assign req_x       = reqX_q;
  assign req_y       = reqY_q;
  assign line_start  = lineStart_q;
  assign frame_start = frameStart_q;
  assign VGA_HS      = hsPipe_q[PIPE_LAT-1] ? HS_POL : ~HS_POL;
  assign VGA_VS      = vsPipe_q[PIPE_LAT-1] ? VS_POL : ~VS_POL;
  assign VGA_BLANK   = blankPipe_q[PIPE_LAT-1];
  assign VGA_SYNC    = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a small 160x90 raster, with a second
// instance at inverted sync polarity.
module tb_vga_timing_gen;

  logic CLK = 1'b0;
  logic NRST;
  logic en;

  logic       aValid, aLs, aFs, aHs, aVs, aBlank, aSync;
  logic [7:0] aX;
  logic [6:0] aY;
  logic       bValid, bLs, bFs, bHs, bVs, bBlank, bSync;
  logic [7:0] bX;
  logic [6:0] bY;

  logic [21:0] aBus, bBus;
  assign aBus = {aValid, aX, aY, aLs, aFs, aHs, aVs, aBlank, aSync};
  assign bBus = {bValid, bX, bY, bLs, bFs, bHs, bVs, bBlank, bSync};

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  vga_timing_gen #(
    .HDISP(160), .VDISP(90), .HFP(4), .HPULSE(8), .HBP(4),
    .VFP(1), .VPULSE(2), .VBP(2), .PIPE_LAT(3), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dutA (
    .CLK(CLK), .NRST(NRST), .en(en),
    .req_valid(aValid), .req_x(aX), .req_y(aY),
    .line_start(aLs), .frame_start(aFs),
    .VGA_HS(aHs), .VGA_VS(aVs), .VGA_BLANK(aBlank), .VGA_SYNC(aSync)
  );

  vga_timing_gen #(
    .HDISP(160), .VDISP(90), .HFP(4), .HPULSE(8), .HBP(4),
    .VFP(1), .VPULSE(2), .VBP(2), .PIPE_LAT(3), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dutB (
    .CLK(CLK), .NRST(NRST), .en(en),
    .req_valid(bValid), .req_x(bX), .req_y(bY),
    .line_start(bLs), .frame_start(bFs),
    .VGA_HS(bHs), .VGA_VS(bVs), .VGA_BLANK(bBlank), .VGA_SYNC(bSync)
  );

  task automatic tickN(input int k);
    for (int i = 0; i < k; i++) @(negedge CLK);
  endtask

  task automatic test_reset();
    NRST = 1'b0;
    en   = 1'b0;
    tickN(2);
    total++;
    if (aBus !== 22'h00000c) begin
      bad++; $display("[TB] FAIL reset_busA: got %h want %h", aBus, 22'h00000c);
    end
    total++;
    if (bBus !== 22'h000000) begin
      bad++; $display("[TB] FAIL reset_busB: got %h want %h", bBus, 22'h000000);
    end
  endtask

  // Edge n after release carries the counts of cycle c=n-1; delayed outputs carry cycle n-4.
  task automatic test_frame();
    int validCnt = 0, blankCnt = 0, hsLow = 0, vsLow = 0, bHsHigh = 0, bVsHigh = 0, syncCnt = 0;
    en   = 1'b1;
    NRST = 1'b1;
    for (int n = 1; n <= 16896; n++) begin
      int c, h, v;
      logic expValid;
      logic [7:0] expX;
      logic [6:0] expY;
      tickN(1);
      c = n - 1;
      h = c % 176;
      v = (c / 176) % 95;
      expValid = (h >= 16) && (v >= 5);
      expX = expValid ? 8'(h - 16) : 8'd0;
      expY = expValid ? 7'(v - 5) : 7'd0;
      total++;
      if ({aValid, aX, aY} !== {expValid, expX, expY}) begin
        bad++; $display("[TB] FAIL req n=%0d: got %b/%0d/%0d want %b/%0d/%0d",
                        n, aValid, aX, aY, expValid, expX, expY);
      end
      total++;
      if ({aLs, aFs} !== {(h == 0), (h == 0 && v == 0)}) begin
        bad++; $display("[TB] FAIL starts n=%0d: got %b%b want %b%b",
                        n, aLs, aFs, (h == 0), (h == 0 && v == 0));
      end
      if (n <= 16720 && aValid === 1'b1) validCnt++;
      if (n >= 4 && n <= 16723) begin
        if (aBlank === 1'b1) blankCnt++;
        if (aHs === 1'b0) hsLow++;
        if (aVs === 1'b0) vsLow++;
        if (bHs === 1'b1) bHsHigh++;
        if (bVs === 1'b1) bVsHigh++;
        if (aSync !== 1'b0) syncCnt++;
      end
      if (n == 7 || n == 16) begin
        total++;
        if ({aHs, bHs} !== 2'b10) begin
          bad++; $display("[TB] FAIL hs_idle n=%0d: got %b%b want 10", n, aHs, bHs);
        end
      end
      if (n == 8 || n == 15) begin
        total++;
        if ({aHs, bHs} !== 2'b01) begin
          bad++; $display("[TB] FAIL hs_pulse n=%0d: got %b%b want 01", n, aHs, bHs);
        end
      end
      if (n == 179 || n == 532) begin
        total++;
        if ({aVs, bVs} !== 2'b10) begin
          bad++; $display("[TB] FAIL vs_idle n=%0d: got %b%b want 10", n, aVs, bVs);
        end
      end
      if (n == 180 || n == 531) begin
        total++;
        if ({aVs, bVs} !== 2'b01) begin
          bad++; $display("[TB] FAIL vs_pulse n=%0d: got %b%b want 01", n, aVs, bVs);
        end
      end
      if (n == 899 || n == 900) begin
        total++;
        if (aBlank !== (n == 900)) begin
          bad++; $display("[TB] FAIL blank_rise n=%0d: got %b want %b", n, aBlank, (n == 900));
        end
      end
      if (n == 16720) begin
        total++;
        if ({aValid, aX, aY} !== {1'b1, 8'd159, 7'd89}) begin
          bad++; $display("[TB] FAIL last_req: got %b/%0d/%0d want 1/159/89", aValid, aX, aY);
        end
      end
    end
    total++;
    if (validCnt != 14400) begin bad++; $display("[TB] FAIL valid_count: got %0d want 14400", validCnt); end
    total++;
    if (blankCnt != 14400) begin bad++; $display("[TB] FAIL blank_count: got %0d want 14400", blankCnt); end
    total++;
    if (hsLow != 760) begin bad++; $display("[TB] FAIL hs_low_count: got %0d want 760", hsLow); end
    total++;
    if (vsLow != 352) begin bad++; $display("[TB] FAIL vs_low_count: got %0d want 352", vsLow); end
    total++;
    if (bHsHigh != 760) begin bad++; $display("[TB] FAIL hs_pol_count: got %0d want 760", bHsHigh); end
    total++;
    if (bVsHigh != 352) begin bad++; $display("[TB] FAIL vs_pol_count: got %0d want 352", bVsHigh); end
    total++;
    if (syncCnt != 0) begin bad++; $display("[TB] FAIL sync_tied: got %0d want 0", syncCnt); end
  endtask

  task automatic test_enable();
    int leak = 0;
    tickN(755);
    total++;
    if ({aValid, aX, aY} !== {1'b1, 8'd34, 7'd0}) begin
      bad++; $display("[TB] FAIL pre_freeze: got %b/%0d/%0d want 1/34/0", aValid, aX, aY);
    end
    en = 1'b0;
    tickN(2);
    total++;
    if ({aValid, aX, aY, aBlank} !== {1'b0, 8'd0, 7'd0, 1'b1}) begin
      bad++; $display("[TB] FAIL freeze_req: got %b/%0d/%0d/%b want 0/0/0/1", aValid, aX, aY, aBlank);
    end
    tickN(1);
    total++;
    if (aBlank !== 1'b1) begin bad++; $display("[TB] FAIL freeze_blank2: got %b want 1", aBlank); end
    tickN(1);
    total++;
    if (aBlank !== 1'b0) begin bad++; $display("[TB] FAIL freeze_blank3: got %b want 0", aBlank); end
    for (int i = 0; i < 46; i++) begin
      tickN(1);
      if ({aValid, aLs, aFs, aBlank} !== 4'b0000) leak++;
    end
    total++;
    if (leak != 0) begin bad++; $display("[TB] FAIL freeze_hold: got %0d active cycles want 0", leak); end
    en = 1'b1;
    tickN(1);
    total++;
    if ({aValid, aX, aY} !== {1'b1, 8'd35, 7'd0}) begin
      bad++; $display("[TB] FAIL resume_req: got %b/%0d/%0d want 1/35/0", aValid, aX, aY);
    end
    tickN(2);
    total++;
    if (aBlank !== 1'b0) begin bad++; $display("[TB] FAIL resume_blank2: got %b want 0", aBlank); end
    tickN(1);
    total++;
    if (aBlank !== 1'b1) begin bad++; $display("[TB] FAIL resume_blank3: got %b want 1", aBlank); end
  endtask

  task automatic test_reset_mid();
    int residue = 0;
    NRST = 1'b0;
    #1;
    total++;
    if (aBus !== 22'h00000c) begin
      bad++; $display("[TB] FAIL midreset_busA: got %h want %h", aBus, 22'h00000c);
    end
    total++;
    if (bBus !== 22'h000000) begin
      bad++; $display("[TB] FAIL midreset_busB: got %h want %h", bBus, 22'h000000);
    end
    tickN(3);
    total++;
    if (aBus !== 22'h00000c) begin
      bad++; $display("[TB] FAIL midreset_hold: got %h want %h", aBus, 22'h00000c);
    end
    NRST = 1'b1;
    tickN(1);
    total++;
    if ({aValid, aLs, aFs, aBlank} !== 4'b0110) begin
      bad++; $display("[TB] FAIL restart_first: got %b want 0110", {aValid, aLs, aFs, aBlank});
    end
    for (int i = 0; i < 6; i++) begin
      tickN(1);
      if ({aLs, aFs, aHs, aVs, aBlank} !== 5'b00110) residue++;
    end
    total++;
    if (residue != 0) begin bad++; $display("[TB] FAIL restart_residue: got %0d bad cycles want 0", residue); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
